riscv_alu_arb: RTL and testbench
================================

# riscv_alu_arb

Round-robin arbiter and sequencer that shares one `riscv_alu` instance among `NREQ` requesters (e.g. integer pipe, address-gen unit, debug/CSR path). Each requester submits operands and an ALU control code through a valid/ready handshake. The block captures the winning request, drives the internal ALU from registered operands, and returns a registered result with its own valid/ready handshake. It sits between the requesters and the ALU and is the only block that drives `riscv_alu` inputs.

## Interface
- `NREQ`, 2: number of requesters, 2..8. Datapath width is `` `XLEN `` (32).
- `i_clk`  in  1  clock, rising edge.
- `i_rstn`  in  1  reset, asynchronous, active-low.
- `i_req_valid`  in  NREQ  request valid, one bit per requester.
- `o_req_ready`  out  NREQ  request accepted, one-hot or zero.
- `i_req_a`  in  NREQ*XLEN  operand A. Requester k occupies `[k*XLEN +: XLEN]`.
- `i_req_b`  in  NREQ*XLEN  operand B, same packing.
- `i_req_ctrl`  in  NREQ*5  ALU control (`` `ALU_CTRL_* ``). Requester k occupies `[k*5 +: 5]`.
- `o_rsp_valid`  out  NREQ  result valid for requester k, one-hot or zero.
- `i_rsp_ready`  in  NREQ  requester k consumes the result.
- `o_rsp_result`  out  XLEN  registered ALU result, shared by all requesters.
- `o_rsp_zero`  out  1  registered ALU zero flag.
- `o_busy`  out  1  high when the FSM state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant = first requester with `i_req_valid` high, searching upward from `rr_ptr` with wrap at NREQ-1 → 0.
  - `o_req_ready[grant]` = 1, combinational, same cycle. All other ready bits are 0.
  - On the accepting edge: capture `a`, `b`, `ctrl` and the grant index into registers; go to EXEC.
  - With no valid request, stay in IDLE; all ready bits are 0.
- EXEC:
  - ALU inputs are driven only from the captured registers.
  - At the end of the cycle, `o_rsp_result` and `o_rsp_zero` register the ALU outputs; go to RESP.
- RESP:
  - `o_rsp_valid[grant]` = 1.
  - When `i_rsp_ready[grant]` = 1: `rr_ptr` ← (grant+1) mod NREQ; go to IDLE.
  - Otherwise stay in RESP. Result and valid are held stable.
  - `i_rsp_ready` bits of non-granted requesters are ignored.
- `o_req_ready` is 0 in EXEC and RESP. There is one outstanding operation at most.
- Requesters hold `valid` and operands stable until ready. The arbiter samples them only on the accepting edge; later changes do not affect an accepted operation.
- A requester may drop `valid` before it is granted without any side effect.
- Result semantics are exactly those of `riscv_alu`:
  - shift amount = `b[4:0]`;
  - SLT/SLTU return 0 or 1 zero-extended;
  - undefined ctrl codes return whatever `riscv_alu` returns, with no error flag.
- Reset values: state IDLE, `rr_ptr` 0, captured registers 0, `o_rsp_result` 0, `o_rsp_zero` 0, `o_rsp_valid` 0, `o_req_ready` 0, `o_busy` 0.
- Reset asserted mid-operation (EXEC or RESP): the operation is discarded, all outputs return to reset values immediately (asynchronous), and no response is produced after reset is released.

## Timing
- Accept edge at the end of cycle T (ready & valid). EXEC in cycle T+1. `o_rsp_valid` high from cycle T+2.
- Minimum occupancy is 3 cycles per operation: IDLE-accept, EXEC, RESP with ready already high. The next accept is possible in cycle T+3.
- `o_rsp_result`, `o_rsp_zero` and `o_rsp_valid` are register outputs with no combinational path from any input.
- `o_req_ready` is combinational from `i_req_valid`, `rr_ptr` and state.
- `o_busy` is 0 in the accepting cycle and 1 in cycles T+1 and T+2.

## Test plan
- **Single ADD:** after reset, req0 issues `ALU_CTRL_ADD`, a=5, b=7 in cycle T. Required: `o_req_ready` = 2'b01 in T; `o_rsp_valid` = 2'b01 in T+2; result 12; zero 0.
- **SUB to zero:** req1 issues `ALU_CTRL_SUB`, a=b=0x1234_5678. Required: result 0, zero 1, `o_rsp_valid` = 2'b10.
- **Round-robin:** both requesters hold valid continuously with `i_rsp_ready` tied high, starting from reset. Required: grants in order 0,1,0,1, spaced 3 cycles apart; the losing requester's ready stays 0 in between.
- **Backpressure:** req0 issues `ALU_CTRL_SRA`, a=0x8000_0000, b=4; `i_rsp_ready` is held low for 5 cycles. Required: result 0xF800_0000 held stable; `o_rsp_valid[0]` stays high; req1's valid gets no ready until the cycle after the response handshake.
- **Reset mid-EXEC:** drop `i_rstn` in the EXEC cycle of an `ALU_CTRL_OR` request. Required: all outputs 0 immediately; no `o_rsp_valid` after reset release; next grant goes to requester 0.
- **Operand change after accept:** req0 issues ADD 1+1, then changes a to 100 in the EXEC cycle. Required: result 2.

Source files
------------

// File: rtl/riscv_alu_arb_if.sv
// Request/response bundle between NREQ requesters and the shared-ALU arbiter.
// Lane k of each vector belongs to requester k.
interface riscv_alu_arb_if #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
);
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ-1:0]      o_req_ready;
  logic [NREQ*XLEN-1:0] i_req_a;
  logic [NREQ*XLEN-1:0] i_req_b;
  logic [NREQ*5-1:0]    i_req_ctrl;
  logic [NREQ-1:0]      o_rsp_valid;
  logic [NREQ-1:0]      i_rsp_ready;
  logic [XLEN-1:0]      o_rsp_result;
  logic                 o_rsp_zero;
  logic                 o_busy;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_req_ctrl, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_zero, o_busy
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_ctrl, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_zero, o_busy
  );
endinterface

// File: rtl/riscv_alu_arb.sv
// Round-robin arbiter sharing one ALU among NREQ requesters: accept, execute
// from captured operands, then hold a registered result until consumed.
`ifndef XLEN
`define XLEN 32
`endif

`ifndef ALU_CTRL_ADD
`define ALU_CTRL_ADD  5'b00000
`define ALU_CTRL_SLL  5'b00001
`define ALU_CTRL_SLT  5'b00010
`define ALU_CTRL_SLTU 5'b00011
`define ALU_CTRL_XOR  5'b00100
`define ALU_CTRL_SRL  5'b00101
`define ALU_CTRL_OR   5'b00110
`define ALU_CTRL_AND  5'b00111
`define ALU_CTRL_SUB  5'b01000
`define ALU_CTRL_SRA  5'b01101
`define ALU_CTRL_LUI  5'b10000
`endif

module riscv_alu_arb #(
  parameter int NREQ = 2
) (
  input logic           i_clk,
  input logic           i_rstn,
  riscv_alu_arb_if.slave bus
);
  localparam int          XLEN = `XLEN;
  localparam int          IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NR   = NREQ;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] grant_q;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW-1:0] cand;
  logic            grant_hit;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] rsp_valid_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [4:0]      ctrl_q;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  int unsigned     k;

  // Search upward from rr_ptr with wrap; ready is forced low while in reset.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = '0;
    k         = 0;
    ready     = '0;
    if (state == IDLE && i_rstn) begin
      for (int unsigned i = 0; i < NR; i++) begin
        k = 32'(rr_ptr) + i;
        if (k >= NR) k = k - NR;
        cand = IDXW'(k);
        if (!grant_hit && bus.i_req_valid[cand]) begin
          grant_hit = 1'b1;
          grant_idx = cand;
        end
      end
      if (grant_hit) ready[grant_idx] = 1'b1;
    end
  end

  // ALU datapath, fed only from the captured operand registers.
  always_comb begin
    shamt      = b_q[4:0];
    alu_result = '0;
    case (ctrl_q)
      `ALU_CTRL_ADD:  alu_result = a_q + b_q;
      `ALU_CTRL_SUB:  alu_result = a_q - b_q;
      `ALU_CTRL_SLL:  alu_result = a_q << shamt;
      `ALU_CTRL_SRL:  alu_result = a_q >> shamt;
      `ALU_CTRL_SRA:  alu_result = $signed(a_q) >>> shamt;
      `ALU_CTRL_SLT:  alu_result[0] = $signed(a_q) < $signed(b_q);
      `ALU_CTRL_SLTU: alu_result[0] = a_q < b_q;
      `ALU_CTRL_XOR:  alu_result = a_q ^ b_q;
      `ALU_CTRL_OR:   alu_result = a_q | b_q;
      `ALU_CTRL_AND:  alu_result = a_q & b_q;
      `ALU_CTRL_LUI:  alu_result = b_q;
      default:        alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_hit) begin
            grant_q <= grant_idx;
            a_q     <= bus.i_req_a[grant_idx*XLEN +: XLEN];
            b_q     <= bus.i_req_b[grant_idx*XLEN +: XLEN];
            ctrl_q  <= bus.i_req_ctrl[grant_idx*5 +: 5];
            state   <= EXEC;
          end
        end
        EXEC: begin
          result_q    <= alu_result;
          zero_q      <= alu_zero;
          rsp_valid_q <= NREQ'(1) << grant_q;
          state       <= RESP;
        end
        RESP: begin
          if (bus.i_rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            rr_ptr      <= (32'(grant_q) == NR - 1) ? '0 : grant_q + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready  = ready;
  assign bus.o_rsp_valid  = rsp_valid_q;
  assign bus.o_rsp_result = result_q;
  assign bus.o_rsp_zero   = zero_q;
  assign bus.o_busy       = (state != IDLE);
endmodule

// File: tb/tb_riscv_alu_arb.sv
// Bench for riscv_alu_arb: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the arbiter.
module tb_riscv_alu_arb;
  localparam int NREQ = 2;
  localparam logic [4:0] C_ADD  = 5'b00000, C_SLL = 5'b00001, C_SLT = 5'b00010,
                         C_SLTU = 5'b00011, C_XOR = 5'b00100, C_SRL = 5'b00101,
                         C_OR   = 5'b00110, C_AND = 5'b00111, C_SUB = 5'b01000,
                         C_SRA  = 5'b01101, C_LUI = 5'b10000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_alu_arb_if #(.NREQ(NREQ), .XLEN(32)) bus ();
  riscv_alu_arb #(.NREQ(NREQ)) dut (.i_clk(clk), .i_rstn(rst_n), .bus(bus.slave));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh = b % 32;
    case (c)
      C_ADD:  return a + b;
      C_SUB:  return a - b;
      C_SLL:  return a << sh;
      C_SRL:  return a >> sh;
      C_SRA:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      C_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      C_SLTU: return (a < b) ? 32'd1 : 32'd0;
      C_XOR:  return a ^ b;
      C_OR:   return a | b;
      C_AND:  return a & b;
      C_LUI:  return b;
      default: return 32'd0;
    endcase
  endfunction

  // Transaction-level model: one operation in flight, tracked by its age.
  bit              have_op = 1'b0;
  int              age, who, rr = 0, m_j, m_new;
  logic [31:0]     m_res;
  logic [NREQ-1:0] e_ready, e_valid;
  logic            e_busy;

  always @(negedge clk) begin
    e_ready = '0;
    e_valid = '0;
    e_busy  = 1'b0;
    m_new   = -1;
    if (!rst_n) begin
      have_op = 1'b0;
      rr      = 0;
      chk("rst_req_ready", bus.o_req_ready, 0);
      chk("rst_rsp_valid", bus.o_rsp_valid, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_result", bus.o_rsp_result, 0);
      chk("rst_zero", bus.o_rsp_zero, 0);
    end else begin
      if (have_op) begin
        age++;
        e_busy = 1'b1;
        if (age >= 2) e_valid[who] = 1'b1;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          m_j = (rr + i) % NREQ;
          if (m_new < 0 && bus.i_req_valid[m_j]) m_new = m_j;
        end
        if (m_new >= 0) e_ready[m_new] = 1'b1;
      end
      chk("req_ready", bus.o_req_ready, e_ready);
      chk("busy", bus.o_busy, e_busy);
      chk("rsp_valid", bus.o_rsp_valid, e_valid);
      if (e_valid != '0) begin
        chk("rsp_result", bus.o_rsp_result, m_res);
        chk("rsp_zero", bus.o_rsp_zero, (m_res == 32'd0) ? 32'd1 : 32'd0);
      end
      if (m_new >= 0) begin
        who     = m_new;
        m_res   = ref_alu(bus.i_req_ctrl[who*5 +: 5], bus.i_req_a[who*32 +: 32],
                          bus.i_req_b[who*32 +: 32]);
        have_op = 1'b1;
        age     = 0;
      end else if (e_valid != '0 && bus.i_rsp_ready[who]) begin
        have_op = 1'b0;
        rr      = (who + 1) % NREQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [4:0] c, input logic [31:0] a,
                         input logic [31:0] b);
    bus.i_req_ctrl[r*5 +: 5] = c;
    bus.i_req_a[r*32 +: 32]  = a;
    bus.i_req_b[r*32 +: 32]  = b;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    step();
    bus.i_rsp_ready = '1;
    look();
    while (bus.o_busy && n < 10) begin
      step();
      look();
      n++;
    end
    chk("idle_timeout", bus.o_busy, 0);
    bus.i_rsp_ready = '0;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rand_ctrl();
    case ($urandom_range(0, 11))
      0: return C_ADD;  1: return C_SUB;  2: return C_SLL;  3: return C_SRL;
      4: return C_SRA;  5: return C_SLT;  6: return C_SLTU; 7: return C_XOR;
      8: return C_OR;   9: return C_AND;  10: return C_LUI;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  logic [NREQ-1:0] last_ready = '0;

  initial begin
    rst_n           = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_req_ctrl  = '0;
    bus.i_rsp_ready = '0;
    step();
    step();
    rst_n = 1'b1;

    chk("model_sra", ref_alu(C_SRA, 32'h8000_0000, 32'd4), 32'hF800_0000);
    chk("model_slt", ref_alu(C_SLT, 32'hFFFF_FFFF, 32'd1), 32'd1);
    chk("model_sltu", ref_alu(C_SLTU, 32'hFFFF_FFFF, 32'd1), 32'd0);
    chk("model_sll", ref_alu(C_SLL, 32'd1, 32'd33), 32'd2);

    // Single ADD from requester 0.
    step(); bus.i_req_valid = 2'b01; set_req(0, C_ADD, 32'd5, 32'd7); look();
    chk("add_ready_T", bus.o_req_ready, 2'b01);
    chk("add_busy_T", bus.o_busy, 0);
    step(); bus.i_req_valid = 2'b00; look();
    chk("add_busy_T1", bus.o_busy, 1);
    chk("add_valid_T1", bus.o_rsp_valid, 2'b00);
    step(); look();
    chk("add_valid_T2", bus.o_rsp_valid, 2'b01);
    chk("add_result", bus.o_rsp_result, 32'd12);
    chk("add_zero", bus.o_rsp_zero, 0);
    step(); bus.i_rsp_ready = 2'b01; look();
    step(); bus.i_rsp_ready = 2'b00; look();
    chk("add_done_busy", bus.o_busy, 0);

    // SUB to zero from requester 1.
    step(); bus.i_req_valid = 2'b10; set_req(1, C_SUB, 32'h1234_5678, 32'h1234_5678);
    bus.i_rsp_ready = 2'b10; look();
    chk("sub_ready", bus.o_req_ready, 2'b10);
    step(); bus.i_req_valid = 2'b00; look();
    step(); look();
    chk("sub_valid", bus.o_rsp_valid, 2'b10);
    chk("sub_result", bus.o_rsp_result, 32'd0);
    chk("sub_zero", bus.o_rsp_zero, 1);
    step(); bus.i_rsp_ready = 2'b00; look();

    // Round-robin with both requesters saturating.
    do_reset();
    step(); bus.i_req_valid = 2'b11; bus.i_rsp_ready = 2'b11;
    set_req(0, C_ADD, 32'd1, 32'd2); set_req(1, C_XOR, 32'hFF, 32'h0F);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      look();
      chk($sformatf("rr_ready_c%0d", c), bus.o_req_ready,
          (c % 3 != 0) ? 32'd0 : (((c / 3) % 2 == 1) ? 32'd2 : 32'd1));
    end
    step(); bus.i_req_valid = 2'b00;
    wait_idle();

    // Backpressure on an SRA result; req1 waits behind it.
    do_reset();
    step(); bus.i_req_valid = 2'b01; set_req(0, C_SRA, 32'h8000_0000, 32'd4);
    bus.i_rsp_ready = 2'b00; look();
    chk("bp_ready_T", bus.o_req_ready, 2'b01);
    step(); bus.i_req_valid = 2'b10; set_req(1, C_ADD, 32'd3, 32'd4);
    bus.i_rsp_ready = 2'b10; look();
    chk("bp_ready_T1", bus.o_req_ready, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step(); look();
      chk("bp_hold_valid", bus.o_rsp_valid, 2'b01);
      chk("bp_hold_result", bus.o_rsp_result, 32'hF800_0000);
      chk("bp_hold_ready", bus.o_req_ready, 2'b00);
    end
    step(); bus.i_rsp_ready = 2'b01; look();
    chk("bp_hs_valid", bus.o_rsp_valid, 2'b01);
    chk("bp_hs_ready", bus.o_req_ready, 2'b00);
    step(); bus.i_rsp_ready = 2'b00; look();
    chk("bp_next_ready", bus.o_req_ready, 2'b10);
    chk("bp_next_valid", bus.o_rsp_valid, 2'b00);
    step(); bus.i_req_valid = 2'b00;
    wait_idle();

    // Reset asserted in the EXEC cycle of an OR.
    step(); bus.i_req_valid = 2'b01; set_req(0, C_OR, 32'hF0, 32'h0F);
    bus.i_rsp_ready = 2'b01; look();
    chk("rx_ready_T", bus.o_req_ready, 2'b01);
    step(); rst_n = 1'b0; bus.i_req_valid = 2'b11; #1;
    chk("rx_async_ready", bus.o_req_ready, 0);
    chk("rx_async_valid", bus.o_rsp_valid, 0);
    chk("rx_async_busy", bus.o_busy, 0);
    chk("rx_async_result", bus.o_rsp_result, 0);
    chk("rx_async_zero", bus.o_rsp_zero, 0);
    look();
    step(); look();
    step(); rst_n = 1'b1; bus.i_req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      look();
      chk("rx_no_rsp", bus.o_rsp_valid, 0);
      chk("rx_no_busy", bus.o_busy, 0);
    end
    step(); bus.i_req_valid = 2'b11; look();
    chk("rx_next_grant", bus.o_req_ready, 2'b01);
    step(); bus.i_req_valid = 2'b00;
    wait_idle();

    // Operand change after accept must not affect the result.
    step(); bus.i_req_valid = 2'b01; set_req(0, C_ADD, 32'd1, 32'd1);
    bus.i_rsp_ready = 2'b00; look();
    chk("oc_ready", bus.o_req_ready, 2'b01);
    step(); bus.i_req_a[31:0] = 32'd100; look();
    step(); look();
    chk("oc_valid", bus.o_rsp_valid, 2'b01);
    chk("oc_result", bus.o_rsp_result, 32'd2);
    bus.i_req_valid = 2'b00;
    wait_idle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      for (int r = 0; r < NREQ; r++) begin
        if (!(bus.i_req_valid[r] && !last_ready[r] && $urandom_range(0, 19) != 0)) begin
          bus.i_req_valid[r] = ($urandom_range(0, 2) != 0);
          bus.i_req_a[r*32 +: 32] = rand_opnd();
          bus.i_req_b[r*32 +: 32] = ($urandom_range(0, 5) == 0) ?
                                    bus.i_req_a[r*32 +: 32] : rand_opnd();
          bus.i_req_ctrl[r*5 +: 5] = rand_ctrl();
        end
      end
      bus.i_rsp_ready = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      look();
      last_ready = bus.o_req_ready;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end
endmodule
